// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment display path.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package sseg_pkg;
  localparam int          NUM_DIGITS = 4;
  localparam logic [3:0]  AN_OFF     = 4'b1111;

  localparam logic [6:0]  SSEG_0     = 7'b1000000;
  localparam logic [6:0]  SSEG_1     = 7'b1111001;
  localparam logic [6:0]  SSEG_2     = 7'b0100100;
  localparam logic [6:0]  SSEG_3     = 7'b0110000;
  localparam logic [6:0]  SSEG_4     = 7'b0011001;
  localparam logic [6:0]  SSEG_5     = 7'b0010010;
  localparam logic [6:0]  SSEG_6     = 7'b0000010;
  localparam logic [6:0]  SSEG_7     = 7'b1111000;
  localparam logic [6:0]  SSEG_8     = 7'b0000000;
  localparam logic [6:0]  SSEG_9     = 7'b0010000;
  localparam logic [6:0]  SSEG_DASH  = 7'b0111111;
  localparam logic [6:0]  SSEG_BLANK = 7'b1111111;
endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD to seven-segment decoder.
//   bcd : 4-bit BCD digit; codes 10-15 render as a dash
//   seg : active-low {g,f,e,d,c,b,a}
module bcd_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = SSEG_DASH;
    case (bcd)
      4'd0: seg = SSEG_0;
      4'd1: seg = SSEG_1;
      4'd2: seg = SSEG_2;
      4'd3: seg = SSEG_3;
      4'd4: seg = SSEG_4;
      4'd5: seg = SSEG_5;
      4'd6: seg = SSEG_6;
      4'd7: seg = SSEG_7;
      4'd8: seg = SSEG_8;
      4'd9: seg = SSEG_9;
      default: seg = SSEG_DASH;
    endcase
  end
endmodule

// File: rtl/bcd_sseg_mux.sv
// Four-digit common-anode seven-segment scanner with frame-latched inputs.
//   clk, reset      : clock, async active-high reset
//   enable          : 1 = scan advances, 0 = freeze counter/index/shadows
//   bcd_0..bcd_3    : digits, bcd_0 leftmost (an_out[0])
//   dp_in           : decimal points, dp_in[i] pairs with bcd_i (1 = lit)
//   an_out          : active-low one-hot anode select (registered)
//   sseg_out        : active-low {dp,g,f,e,d,c,b,a} (registered)
//   frame_tick      : one-cycle pulse after each end-of-frame capture
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit 3 is never blanked; dp remains visible).
module bcd_sseg_mux
  import sseg_pkg::*;
#(
  parameter int REFRESH_POWER = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] bcd_0,
  input  logic [3:0] bcd_1,
  input  logic [3:0] bcd_2,
  input  logic [3:0] bcd_3,
  input  logic [3:0] dp_in,
  output logic [3:0] an_out,
  output logic [7:0] sseg_out,
  output logic       frame_tick
);
  logic [REFRESH_POWER-1:0]          cnt;
  logic [1:0]                        idx;
  logic                              primed;
  logic [NUM_DIGITS-1:0][3:0]        bcd_in;
  logic [NUM_DIGITS-1:0][3:0]        shadow;
  logic [NUM_DIGITS-1:0]             dp_shadow;
  logic [NUM_DIGITS-1:0][6:0]        dec;
  logic [NUM_DIGITS-1:0]             blank;
  logic                              tick;
  logic                              frame_end;
  logic                              capture;
  logic [6:0]                        seg_sel;

  assign bcd_in    = {bcd_3, bcd_2, bcd_1, bcd_0};
  assign tick      = enable && (&cnt);
  assign frame_end = tick && (idx == 2'd3);
  // First edge after reset loads the shadows so the first scan shows real data.
  assign capture   = !primed || frame_end;

  // One decoder per shadowed digit; the scan mux selects among them.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    bcd_to_sseg u_dec (
      .bcd (shadow[g]),
      .seg (dec[g])
    );
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit blanks while every digit to its left (and itself) is zero.
  always_comb begin
    logic zero_run;
    blank    = '0;
    zero_run = 1'b1;
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      zero_run = zero_run && (shadow[i] == 4'd0);
      blank[i] = zero_run;
    end
  end
`else
  assign blank = '0;
`endif

  assign seg_sel = blank[idx] ? SSEG_BLANK : dec[idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      primed     <= 1'b0;
      shadow     <= '0;
      dp_shadow  <= '0;
      an_out     <= AN_OFF;
      sseg_out   <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      if (enable) cnt <= cnt + REFRESH_POWER'(1);
      if (tick)   idx <= idx + 2'd1;
      primed     <= 1'b1;
      frame_tick <= frame_end;
      if (capture) begin
        shadow    <= bcd_in;
        dp_shadow <= dp_in;
      end
      // Outputs stay dark on the priming edge; shadows are not valid until after it.
      if (primed) begin
        an_out   <= ~(4'b0001 << idx);
        sseg_out <= {~dp_shadow[idx], seg_sel};
      end
    end
  end
endmodule

// File: tb/tb_bcd_sseg_mux.sv
module tb_bcd_sseg_mux;
  localparam int RP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] bcd_0, bcd_1, bcd_2, bcd_3, dp_in;
  logic [3:0] an_out;
  logic [7:0] sseg_out;
  logic       frame_tick;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] an;
    logic [7:0] sseg;
    int         dwell;
  } exp_t;
  exp_t sb[$];

  bcd_sseg_mux #(.REFRESH_POWER(RP)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .bcd_0(bcd_0), .bcd_1(bcd_1), .bcd_2(bcd_2), .bcd_3(bcd_3),
    .dp_in(dp_in), .an_out(an_out), .sseg_out(sseg_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  function automatic exp_t mk(input logic [3:0] an, input logic [7:0] s, input int d);
    exp_t e;
    e.an = an; e.sseg = s; e.dwell = d;
    return e;
  endfunction

  // Pop one expected digit per anode change and compare.
  task automatic drain_sb(input string tag);
    logic [3:0] prev;
    exp_t e;
    int cyc;
    prev = an_out;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cyc = 0;
      while (an_out === prev && cyc < 24) begin
        step();
        cyc++;
      end
      n_total++;
      if (an_out !== e.an || sseg_out !== e.sseg)
        $display("FAIL %s digit: an=%b sseg=%h, expected an=%b sseg=%h", tag, an_out, sseg_out, e.an, e.sseg);
      else n_pass++;
      if (e.dwell != 0) begin
        n_total++;
        if (cyc !== e.dwell) $display("FAIL %s dwell: %0d cycles, expected %0d", tag, cyc, e.dwell);
        else n_pass++;
      end
      prev = an_out;
    end
  endtask

  task automatic wait_frame_tick(input string tag);
    int cyc = 0;
    while (frame_tick !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    n_total++;
    if (frame_tick !== 1'b1) $display("FAIL %s frame_tick timeout: frame_tick=%b, expected 1", tag, frame_tick);
    else n_pass++;
  endtask

  task automatic wait_an(input logic [3:0] target, input string tag);
    int cyc = 0;
    logic [3:0] prev;
    prev = an_out;
    while (!(an_out === target && prev !== target) && cyc < 40) begin
      prev = an_out;
      step();
      cyc++;
    end
    n_total++;
    if (an_out !== target) $display("FAIL %s wait an: an=%b, expected %b", tag, an_out, target);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; dp_in = 4'b0000;
    bcd_0 = 4'd1; bcd_1 = 4'd2; bcd_2 = 4'd3; bcd_3 = 4'd4;
    #3;
    n_total++;
    if (an_out !== 4'b1111 || sseg_out !== 8'hFF || frame_tick !== 1'b0)
      $display("FAIL reset_values: an=%b sseg=%h ft=%b, expected 1111 ff 0", an_out, sseg_out, frame_tick);
    else n_pass++;
    step(); step();
    reset = 1'b0;
    step();
    n_total++;
    if (an_out !== 4'b1111 || sseg_out !== 8'hFF)
      $display("FAIL first_edge: an=%b sseg=%h, expected 1111 ff", an_out, sseg_out);
    else n_pass++;
    step();
    n_total++;
    if (an_out !== 4'b1110 || sseg_out !== 8'hF9)
      $display("FAIL second_edge: an=%b sseg=%h, expected 1110 f9", an_out, sseg_out);
    else n_pass++;
    sb.push_back(mk(4'b1101, 8'hA4, 3));
    sb.push_back(mk(4'b1011, 8'hB0, 4));
    sb.push_back(mk(4'b0111, 8'h99, 4));
    sb.push_back(mk(4'b1110, 8'hF9, 4));
    drain_sb("first_scan");
  endtask

  task automatic test_frame_latch();
    int pulses = 0;
    int high = 0;
    bit bad_align = 0;
    logic last_ft = 1'b0;
    bcd_0 = 4'd7;
    step();
    n_total++;
    if (an_out !== 4'b1110 || sseg_out !== 8'hF9)
      $display("FAIL latch_hold: an=%b sseg=%h, expected 1110 f9", an_out, sseg_out);
    else n_pass++;
    sb.push_back(mk(4'b1101, 8'hA4, 0));
    sb.push_back(mk(4'b1011, 8'hB0, 4));
    sb.push_back(mk(4'b0111, 8'h99, 4));
    sb.push_back(mk(4'b1110, 8'hF8, 4));
    drain_sb("latch_update");
    for (int i = 0; i < 32; i++) begin
      step();
      if (frame_tick === 1'b1) begin
        high++;
        if (last_ft !== 1'b1) pulses++;
        if (an_out !== 4'b0111) bad_align = 1;
      end
      last_ft = frame_tick;
    end
    n_total++;
    if (pulses !== 2 || high !== 2)
      $display("FAIL frame_tick_rate: pulses=%0d high=%0d, expected 2 2", pulses, high);
    else n_pass++;
    n_total++;
    if (bad_align) $display("FAIL frame_tick_align: tick outside last digit, expected an=0111");
    else n_pass++;
  endtask

  task automatic test_invalid_dp();
    bcd_2 = 4'hC; dp_in = 4'b0100;
    wait_frame_tick("invalid_dp");
    sb.push_back(mk(4'b1110, 8'hF8, 0));
    sb.push_back(mk(4'b1101, 8'hA4, 4));
    sb.push_back(mk(4'b1011, 8'h3F, 4));
    sb.push_back(mk(4'b0111, 8'h99, 4));
    drain_sb("invalid_dp");
  endtask

  task automatic test_enable_freeze();
    logic [3:0] h_an;
    logic [7:0] h_seg;
    bit moved = 0, ticked = 0;
    int cyc = 0;
    wait_an(4'b1101, "freeze");
    step();
    enable = 1'b0;
    h_an = an_out; h_seg = sseg_out;
    for (int i = 0; i < 20; i++) begin
      step();
      if (an_out !== h_an || sseg_out !== h_seg) moved = 1;
      if (frame_tick !== 1'b0) ticked = 1;
    end
    n_total++;
    if (moved) $display("FAIL freeze_hold: an=%b sseg=%h, expected %b %h", an_out, sseg_out, h_an, h_seg);
    else n_pass++;
    n_total++;
    if (ticked) $display("FAIL freeze_tick: frame_tick seen, expected none");
    else n_pass++;
    enable = 1'b1;
    while (an_out === h_an && cyc < 20) begin
      step();
      cyc++;
    end
    n_total++;
    if (cyc !== 3 || an_out !== 4'b1011 || sseg_out !== 8'h3F)
      $display("FAIL freeze_resume: %0d cycles an=%b sseg=%h, expected 3 1011 3f", cyc, an_out, sseg_out);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    wait_an(4'b1101, "async_reset");
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_total++;
    if (an_out !== 4'b1111 || sseg_out !== 8'hFF || frame_tick !== 1'b0)
      $display("FAIL async_reset: an=%b sseg=%h ft=%b, expected 1111 ff 0", an_out, sseg_out, frame_tick);
    else n_pass++;
    step();
    reset = 1'b0;
    step();
    n_total++;
    if (an_out !== 4'b1111) $display("FAIL async_prime: an=%b, expected 1111", an_out);
    else n_pass++;
    step();
    n_total++;
    if (an_out !== 4'b1110 || sseg_out !== 8'hF8)
      $display("FAIL async_restart: an=%b sseg=%h, expected 1110 f8", an_out, sseg_out);
    else n_pass++;
  endtask

  task automatic test_blank();
    bcd_0 = 4'd0; bcd_1 = 4'd0; bcd_2 = 4'd4; bcd_3 = 4'd0; dp_in = 4'b0000;
    wait_frame_tick("blank");
`ifdef LEADING_ZERO_BLANK_EN
    sb.push_back(mk(4'b1110, 8'hFF, 0));
    sb.push_back(mk(4'b1101, 8'hFF, 4));
`else
    sb.push_back(mk(4'b1110, 8'hC0, 0));
    sb.push_back(mk(4'b1101, 8'hC0, 4));
`endif
    sb.push_back(mk(4'b1011, 8'h99, 4));
    sb.push_back(mk(4'b0111, 8'hC0, 4));
    drain_sb("blank");
  endtask

  initial begin
    test_reset();
    test_frame_latch();
    test_invalid_dp();
    test_enable_freeze();
    test_async_reset();
    test_blank();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
